// File: rtl/me_pkg.sv
// Dimensions, FSM encoding and framing helper shared by the window loader and the
// motion-estimator control unit.
package me_pkg;

  localparam int PIXEL_W     = 8;
  localparam int R_DIM       = 16;
  localparam int S_DIM       = 32;
  localparam int R_PIXELS    = R_DIM * R_DIM;
  localparam int S_PIXELS    = S_DIM * S_DIM;
  localparam int TOTAL_BEATS = R_PIXELS + S_PIXELS;

  typedef logic [2:0] loader_state_t;

  localparam loader_state_t ST_IDLE   = 3'd0;
  localparam loader_state_t ST_LOAD_R = 3'd1;
  localparam loader_state_t ST_LOAD_S = 3'd2;
  localparam loader_state_t ST_RUN    = 3'd3;
  localparam loader_state_t ST_DONE   = 3'd4;

  // A beat is mis-framed when pix_last disagrees with whether it is the final beat.
  function automatic logic framing_err(input logic final_beat, input logic last);
    return final_beat ^ last;
  endfunction

endpackage

// File: rtl/me_window_loader.sv
// Streams 256 reference pixels then 1024 search-window pixels into the R/S memories,
// then holds start to the control unit until completed returns.
module me_window_loader #(
  parameter int PIXEL_W = 8,
  parameter int R_DIM   = 16,
  parameter int S_DIM   = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               go,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [PIXEL_W-1:0] pix_data,
  input  logic               pix_last,
  output logic               r_we,
  output logic [7:0]         r_addr,
  output logic [PIXEL_W-1:0] r_wdata,
  output logic               s_we,
  output logic [9:0]         s_addr,
  output logic [PIXEL_W-1:0] s_wdata,
  output logic               start,
  input  logic               completed,
  output logic               busy,
  output logic               done,
  output logic               load_err
);
  import me_pkg::*;

  localparam int          RP    = R_DIM * R_DIM;
  localparam int          TB    = RP + S_DIM * S_DIM;
  localparam logic [10:0] R_END = 11'(RP - 1);
  localparam logic [10:0] S_END = 11'(TB - 1);

  loader_state_t state, state_nx;
  logic [10:0]   cnt;
  logic          hs, final_beat, bad_frame, go_ok;
  logic          wr_r_p0, wr_s_p0;

  assign pix_ready  = (state == ST_LOAD_R) || (state == ST_LOAD_S);
  assign hs         = pix_valid && pix_ready;
  assign final_beat = (state == ST_LOAD_S) && (cnt == S_END);
  assign bad_frame  = hs && framing_err(final_beat, pix_last);
  assign go_ok      = (state == ST_IDLE) && go;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign wr_r_p0    = hs && (state == ST_LOAD_R);
  assign wr_s_p0    = hs && (state == ST_LOAD_S);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (go) state_nx = ST_LOAD_R;
      ST_LOAD_R: begin
        if (bad_frame)                state_nx = ST_IDLE;
        else if (hs && cnt == R_END)  state_nx = ST_LOAD_S;
      end
      ST_LOAD_S: begin
        if (bad_frame)                state_nx = ST_IDLE;
        else if (hs && final_beat)    state_nx = ST_RUN;
      end
      // completed only counts once start has actually been presented
      ST_RUN:    if (completed && start) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      load_err <= 1'b0;
      start    <= 1'b0;
    end else begin
      state <= state_nx;
      if (go_ok)    cnt <= '0;
      else if (hs)  cnt <= cnt + 11'd1;
      if (go_ok)          load_err <= 1'b0;
      else if (bad_frame) load_err <= 1'b1;
      // one RUN cycle with start low lets the final write land first
      start <= (state == ST_RUN) && !(completed && start);
    end
  end

  // Stage p0 -> p1: registered memory write ports
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
    end else begin
      r_we <= wr_r_p0;
      s_we <= wr_s_p0;
      if (wr_r_p0) begin
        r_addr  <= cnt[7:0];
        r_wdata <= pix_data;
      end
      if (wr_s_p0) begin
        s_addr  <= cnt[9:0] - 10'(RP);
        s_wdata <= pix_data;
      end
    end
  end

endmodule

// File: tb/tb_me_window_loader.sv
// Directed bench for me_window_loader: models both memories from the write ports
// and checks framing, handshake timing and the start/completed/done sequence.
module tb_me_window_loader;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       go = 1'b1;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [7:0] pix_data = 8'd0;
  logic       pix_last = 1'b0;
  logic       r_we, s_we;
  logic [7:0] r_addr, r_wdata, s_wdata;
  logic [9:0] s_addr;
  logic       start;
  logic       completed = 1'b0;
  logic       busy, done, load_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_total = 0, both_total = 0, start_total = 0, done_total = 0;
  logic [7:0] r_mem [256];
  logic [7:0] s_mem [1024];

  me_window_loader #(.PIXEL_W(8), .R_DIM(16), .S_DIM(32)) dut (
    .clock(clock), .reset_n(reset_n), .go(go),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last),
    .r_we(r_we), .r_addr(r_addr), .r_wdata(r_wdata),
    .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .start(start), .completed(completed), .busy(busy), .done(done), .load_err(load_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (r_we) r_mem[r_addr] <= r_wdata;
    if (s_we) s_mem[s_addr] <= s_wdata;
    if (r_we || s_we) wr_total <= wr_total + 1;
    if (r_we && s_we) both_total <= both_total + 1;
    if (start) start_total <= start_total + 1;
    if (done) done_total <= done_total + 1;
  end

  task automatic do_go();
    @(negedge clock); go = 1'b1;
    @(negedge clock); go = 1'b0;
  endtask

  // Beat k carries k mod 256; pix_last on beat bad_last, and on 1279 unless no_last.
  task automatic stream(input int gap, input int bad_last, input bit no_last, output int sent);
    sent = 0;
    for (int k = 0; k < 1280; k++) begin
      while (gap > 0 && $urandom_range(99) < gap) begin
        pix_valid = 1'b0;
        @(negedge clock);
      end
      if (!pix_ready) break;
      pix_valid = 1'b1;
      pix_data  = 8'(k);
      pix_last  = (k == bad_last) || (k == 1279 && !no_last);
      sent++;
      @(negedge clock);
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic complete_pass(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (start) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    if (ok) begin
      completed = 1'b1;
      @(negedge clock);
      completed = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    logic [40:0] outs;
    repeat (3) @(negedge clock);
    outs = {pix_ready, r_we, r_addr, r_wdata, s_we, s_addr, s_wdata, start, busy, done, load_err};
    checks++;
    if (outs !== 41'd0) begin errors++; $display("FAIL reset_outs: got %h want 0", outs); end
    @(negedge clock); reset_n = 1'b1; go = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || pix_ready !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b ready=%b want 0 0", busy, pix_ready);
    end
  endtask

  task automatic test_full_stream();
    int sent, c0, w0, b0, d0, bad_r, bad_s;
    w0 = wr_total; b0 = both_total; d0 = done_total;
    do_go();
    checks++;
    if (busy !== 1'b1 || pix_ready !== 1'b1) begin
      errors++; $display("FAIL go_busy: busy=%b ready=%b want 1 1", busy, pix_ready);
    end
    c0 = cyc;
    stream(0, -1, 1'b0, sent);
    checks++;
    if (sent != 1280 || cyc - c0 != 1280) begin
      errors++; $display("FAIL min_load: beats=%0d cycles=%0d want 1280 1280", sent, cyc - c0);
    end
    checks++;
    if (s_we !== 1'b1 || s_addr !== 10'd1023 || s_wdata !== 8'd255 || start !== 1'b0) begin
      errors++;
      $display("FAIL last_write: s_we=%b addr=%0d data=%0d start=%b want 1 1023 255 0",
               s_we, s_addr, s_wdata, start);
    end
    @(negedge clock);
    checks++;
    if (start !== 1'b1 || s_we !== 1'b0) begin
      errors++; $display("FAIL start_rise: start=%b s_we=%b want 1 0", start, s_we);
    end
    repeat (3) @(negedge clock);
    completed = 1'b1;
    @(negedge clock);
    completed = 1'b0;
    checks++;
    if (done !== 1'b1 || start !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL done_pulse: done=%b start=%b busy=%b want 1 0 1", done, start, busy);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || load_err !== 1'b0) begin
      errors++; $display("FAIL after_done: done=%b busy=%b err=%b want 0 0 0", done, busy, load_err);
    end
    @(negedge clock);
    bad_r = 0; bad_s = 0;
    for (int a = 0; a < 256; a++) if (r_mem[a] !== 8'(a)) bad_r++;
    for (int a = 0; a < 1024; a++) if (s_mem[a] !== 8'(a + 256)) bad_s++;
    checks++;
    if (bad_r != 0) begin errors++; $display("FAIL r_mem: bad=%0d want 0", bad_r); end
    checks++;
    if (bad_s != 0) begin errors++; $display("FAIL s_mem: bad=%0d want 0", bad_s); end
    checks++;
    if (wr_total - w0 != 1280 || both_total != b0 || done_total - d0 != 1) begin
      errors++;
      $display("FAIL full_counts: writes=%0d both=%0d dones=%0d want 1280 0 1",
               wr_total - w0, both_total - b0, done_total - d0);
    end
  endtask

  task automatic test_gaps();
    int sent, w0, b0, bad;
    bit ok;
    w0 = wr_total; b0 = both_total;
    do_go();
    stream(30, -1, 1'b0, sent);
    complete_pass(ok);
    @(negedge clock);
    checks++;
    if (!ok || sent != 1280) begin
      errors++; $display("FAIL gap_run: start_seen=%b beats=%0d want 1 1280", ok, sent);
    end
    checks++;
    if (wr_total - w0 != 1280 || both_total != b0) begin
      errors++;
      $display("FAIL gap_writes: writes=%0d both=%0d want 1280 0", wr_total - w0, both_total - b0);
    end
    bad = 0;
    for (int a = 0; a < 256; a++) if (r_mem[a] !== 8'(a)) bad++;
    for (int a = 0; a < 1024; a++) if (s_mem[a] !== 8'(a)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL gap_mem: bad=%0d want 0", bad); end
  endtask

  task automatic test_early_last();
    int sent, s0;
    bit ok;
    s0 = start_total;
    do_go();
    stream(0, 700, 1'b0, sent);
    checks++;
    if (sent != 701 || load_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL early_last: beats=%0d err=%b busy=%b want 701 1 0", sent, load_err, busy);
    end
    repeat (5) @(negedge clock);
    checks++;
    if (start_total != s0 || load_err !== 1'b1) begin
      errors++;
      $display("FAIL early_nostart: start_cycles=%0d err=%b want 0 1", start_total - s0, load_err);
    end
    do_go();
    checks++;
    if (load_err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL err_clear: err=%b busy=%b want 0 1", load_err, busy);
    end
    stream(0, -1, 1'b0, sent);
    complete_pass(ok);
    checks++;
    if (!ok || load_err !== 1'b0) begin
      errors++; $display("FAIL reload: start_seen=%b err=%b want 1 0", ok, load_err);
    end
  endtask

  task automatic test_missing_last();
    int sent, s0;
    s0 = start_total;
    do_go();
    stream(0, -1, 1'b1, sent);
    checks++;
    if (sent != 1280 || load_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL missing_last: beats=%0d err=%b busy=%b want 1280 1 0", sent, load_err, busy);
    end
    repeat (5) @(negedge clock);
    checks++;
    if (start_total != s0) begin
      errors++; $display("FAIL missing_nostart: start_cycles=%0d want 0", start_total - s0);
    end
  endtask

  task automatic test_reset_in_run();
    int sent, d0, bad;
    bit ok;
    d0 = done_total;
    do_go();
    stream(0, -1, 1'b0, sent);
    repeat (3) @(negedge clock);
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL run_start: start=%b want 1", start); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (start !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL async_drop: start=%b busy=%b done=%b want 0 0 0", start, busy, done);
    end
    @(negedge clock); reset_n = 1'b1;
    repeat (4) @(negedge clock);
    checks++;
    if (done_total != d0 || busy !== 1'b0) begin
      errors++; $display("FAIL no_done: dones=%0d busy=%b want 0 0", done_total - d0, busy);
    end
    do_go();
    stream(0, -1, 1'b0, sent);
    complete_pass(ok);
    @(negedge clock);
    bad = 0;
    for (int a = 0; a < 1024; a++) if (s_mem[a] !== 8'(a)) bad++;
    checks++;
    if (!ok || done_total - d0 != 1 || bad != 0) begin
      errors++;
      $display("FAIL post_reset_run: start_seen=%b dones=%0d bad=%0d want 1 1 0",
               ok, done_total - d0, bad);
    end
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_gaps();
    test_early_last();
    test_missing_last();
    test_reset_in_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
